// File: rtl/jh512_msg_padder.sv
// JH-512 message padder: packs 64-bit message words into 128-bit core beats and
// appends the 0x80 marker, zero fill and the 128-bit big-endian bit length.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_MSG   | accepting message words from the input stream
// S_FILL  | generating zero words (plus pending marker) up to the block boundary
// S_FINAL | generating the padding-only final block that carries the length
module jh512_msg_padder #(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_data,
   input  logic         in_last,
   input  logic [3:0]   in_bytes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_block_first,
   output logic         out_block_last,
   output logic         out_msg_last
);

   typedef enum logic [1:0] {
      S_MSG   = 2'd0,
      S_FILL  = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic               run;
   logic [5:0]         pos;
   logic [LEN_W-1:0]   len_bits;
   logic [LEN_W-1:0]   len_add;
   logic               mark_pend;
   logic [63:0]        stage_hi;
   logic [63:0]        word;
   logic               wr_word;
   logic               mark_clr;
   logic               msg_done;
   logic               ob_free;
   logic [3:0]         nbytes;
   logic [127:0]       len128;

   // pos is always word aligned, so pos[3] set means the high half is staged
   // and the next word completes a beat; only then does a full buffer block us.
   assign in_ready = run && (state == S_MSG) && !(pos[3] && out_valid);
   assign ob_free  = !out_valid || out_ready;
   assign len128   = 128'(len_bits);

   // Next-state logic and the 64-bit word to be written into the staging pair
   always_comb begin
      state_nx = state;
      word     = '0;
      wr_word  = 1'b0;
      nbytes   = 4'd8;
      len_add  = '0;
      mark_clr = 1'b0;
      msg_done = 1'b0;
      case (state)
         S_MSG: begin
            if (in_valid && in_ready) begin
               if (in_last && (in_bytes < 4'd8)) nbytes = in_bytes;
               for (int i = 0; i < 8; i++) begin
                  if (4'(i) < nbytes) word[63-8*i -: 8] = in_data[63-8*i -: 8];
                  else if (4'(i) == nbytes) word[63-8*i -: 8] = 8'h80;
               end
               len_add = LEN_W'({nbytes, 3'b000});
               // An empty last word occupies no byte slot in the block.
               wr_word = (nbytes != 4'd0);
               if (in_last) begin
                  mark_clr = (nbytes != 4'd0) && (nbytes != 4'd8);
                  if ((wr_word && (pos[5:3] == 3'd7)) || (!wr_word && (pos == 6'd0)))
                     state_nx = S_FINAL;
                  else
                     state_nx = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (!pos[3] || ob_free) begin
               wr_word  = 1'b1;
               word     = {(mark_pend ? 8'h80 : 8'h00), 56'd0};
               mark_clr = mark_pend;
               if (pos[5:3] == 3'd7) state_nx = S_FINAL;
            end
         end
         S_FINAL: begin
            if (!pos[3] || ob_free) begin
               wr_word = 1'b1;
               case (pos[5:3])
                  3'd0:    word = {(mark_pend ? 8'h80 : 8'h00), 56'd0};
                  3'd6:    word = len128[127:64];
                  3'd7:    word = len128[63:0];
                  default: word = '0;
               endcase
               if (pos[5:3] == 3'd7) begin
                  msg_done = 1'b1;
                  state_nx = S_MSG;
               end
            end
         end
         default: state_nx = S_MSG;
      endcase
   end

   // State, counters, staging register and one-entry output buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_MSG;
         run             <= 1'b0;
         pos             <= '0;
         len_bits        <= '0;
         mark_pend       <= 1'b1;
         stage_hi        <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_block_first <= 1'b0;
         out_block_last  <= 1'b0;
         out_msg_last    <= 1'b0;
      end else begin
         run   <= 1'b1;
         state <= state_nx;

         if (msg_done) begin
            len_bits  <= '0;
            mark_pend <= 1'b1;
         end else begin
            len_bits <= len_bits + len_add;
            if (mark_clr) mark_pend <= 1'b0;
         end

         if (out_valid && out_ready) begin
            out_valid       <= 1'b0;
            out_block_first <= 1'b0;
            out_block_last  <= 1'b0;
            out_msg_last    <= 1'b0;
         end

         if (wr_word) begin
            pos <= msg_done ? 6'd0 : pos + 6'd8;
            if (!pos[3]) begin
               stage_hi <= word;
            end else begin
               out_data        <= {stage_hi, word};
               out_valid       <= 1'b1;
               out_block_first <= (pos[5:4] == 2'd0);
               out_block_last  <= (pos[5:4] == 2'd3);
               out_msg_last    <= (state == S_FINAL) && (pos[5:4] == 2'd3);
            end
         end
      end
   end

endmodule

// File: tb/tb_jh512_msg_padder.sv
// Bench for jh512_msg_padder: directed padding cases plus randomized traffic,
// checked against a byte-level padding model.
module tb_jh512_msg_padder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [63:0]  in_data = '0;
   logic         in_last = 1'b0;
   logic [3:0]   in_bytes = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         out_block_first;
   logic         out_block_last;
   logic         out_msg_last;

   int total = 0;
   int bad   = 0;

   byte unsigned msg_q[$];
   logic [127:0] got[$];
   logic [127:0] ref_run[$];

   jh512_msg_padder #(.LEN_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_bytes(in_bytes),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_block_first(out_block_first), .out_block_last(out_block_last),
      .out_msg_last(out_msg_last)
   );

   always #5 clk = ~clk;

   // Send msg_q through the DUT and compare every beat with the padding model.
   task automatic run_msg(input bit rnd_in, input bit rnd_out, input bit stall,
                          input bit empty_last);
      byte unsigned exp_b[$];
      logic [127:0] exp_beats[$];
      logic [63:0]  wd[$];
      bit           wl[$];
      logic [3:0]   wb[$];
      logic [127:0] lenv, bt, held;
      logic [2:0]   heldf, expf, curf;
      logic [63:0]  w;
      int L, tot_len, full, rem, nw, wi, bi, cyc, stall_left;
      bit stall_done, was_stalled;

      L = msg_q.size();
      tot_len = L + 64 + ((64 - (L % 64)) % 64);
      foreach (msg_q[k]) exp_b.push_back(msg_q[k]);
      exp_b.push_back(8'h80);
      while (exp_b.size() < tot_len - 16) exp_b.push_back(8'h00);
      lenv = 128'(L) << 3;
      for (int k = 15; k >= 0; k--) exp_b.push_back(lenv[8*k +: 8]);
      for (int j = 0; j < tot_len / 16; j++) begin
         bt = '0;
         for (int k = 0; k < 16; k++) bt = {bt[119:0], exp_b[16*j + k]};
         exp_beats.push_back(bt);
      end

      full = L / 8;
      rem  = L % 8;
      if (rem != 0)                     nw = full + 1;
      else if (L == 0 || empty_last)    nw = full + 1;
      else                              nw = full;
      for (int i = 0; i < nw; i++) begin
         for (int k = 0; k < 8; k++)
            w[63-8*k -: 8] = (i*8 + k < L) ? msg_q[i*8 + k] : 8'($urandom);
         wd.push_back(w);
         if (i == nw - 1) begin
            wl.push_back(1'b1);
            if (rem != 0)            wb.push_back(4'(rem));
            else if (i == full)      wb.push_back(4'd0);
            else                     wb.push_back(4'($urandom_range(8, 15)));
         end else begin
            wl.push_back(1'b0);
            wb.push_back(4'($urandom_range(0, 15)));
         end
      end

      got.delete();
      wi = 0; bi = 0; cyc = 0; stall_left = 0;
      stall_done = 0; was_stalled = 0;
      held = '0; heldf = '0;
      while (bi < exp_beats.size() && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (stall && !stall_done && wi == 2) begin
            stall_left = 10;
            stall_done = 1;
         end
         if (wi < nw && (stall_left > 0 || !rnd_in || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_data  = wd[wi];
            in_last  = wl[wi];
            in_bytes = wb[wi];
         end else begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            in_last  = 1'($urandom);
            in_bytes = 4'($urandom);
         end
         if (stall_left > 0) out_ready = 1'b0;
         else out_ready = rnd_out ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         curf = {out_block_first, out_block_last, out_msg_last};
         if (was_stalled) begin
            total++;
            if (out_data !== held || curf !== heldf || out_valid !== 1'b1) begin
               bad++;
               $display("FAIL hold_stable: got data=%h flags=%b v=%b want data=%h flags=%b v=1",
                        out_data, curf, out_valid, held, heldf);
            end
         end
         if (stall_left == 1) begin
            total++;
            if (in_ready !== 1'b0) begin
               bad++;
               $display("FAIL in_ready_stall: got %b want 0", in_ready);
            end
         end
         if (stall_left > 0) stall_left--;
         was_stalled = out_valid && !out_ready;
         held  = out_data;
         heldf = curf;
         if (out_valid && out_ready) begin
            expf = {(bi % 4 == 0), (bi % 4 == 3), (bi == exp_beats.size() - 1)};
            total++;
            if (out_data !== exp_beats[bi] || curf !== expf) begin
               bad++;
               $display("FAIL beat[%0d] L=%0d: got %h flags=%b want %h flags=%b",
                        bi, L, out_data, curf, exp_beats[bi], expf);
            end
            got.push_back(out_data);
            bi++;
         end
         if (in_valid && in_ready) wi++;
      end
      total++;
      if (bi != exp_beats.size() || wi != nw) begin
         bad++;
         $display("FAIL msg_complete L=%0d: got beats=%0d words=%0d want beats=%0d words=%0d",
                  L, bi, wi, exp_beats.size(), nw);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_block_first, out_block_last, out_msg_last} !== 5'b0
          || out_data !== 128'd0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b rdy=%b data=%h want all 0",
                  out_valid, in_ready, out_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset: got %b want 1", in_ready);
      end
   endtask

   task automatic test_empty();
      msg_q.delete();
      run_msg(0, 0, 0, 0);
      total++;
      if (got.size() != 4 || got[0] !== {8'h80, 120'd0} || got[3] !== 128'd0) begin
         bad++;
         $display("FAIL empty_lit: got n=%0d b0=%h want n=4 b0=%h", got.size(),
                  (got.size() > 0) ? got[0] : 128'd0, {8'h80, 120'd0});
      end
   endtask

   task automatic check_abc(input string nm);
      total++;
      if (got.size() != 8 || got[0] !== {32'h61626380, 96'd0} || got[7] !== 128'h18) begin
         bad++;
         $display("FAIL %s: got n=%0d b0=%h b7=%h want n=8 b0=%h b7=%h", nm, got.size(),
                  (got.size() > 0) ? got[0] : 128'd0, (got.size() > 7) ? got[7] : 128'd0,
                  {32'h61626380, 96'd0}, 128'h18);
      end
   endtask

   task automatic test_abc();
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 0, 0, 0);
      check_abc("abc_lit");
   endtask

   task automatic test_block_64();
      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
      run_msg(0, 0, 0, 0);
      total++;
      if (got.size() != 8 || got[4] !== {8'h80, 120'd0} || got[7] !== 128'h200) begin
         bad++;
         $display("FAIL len64_lit: got n=%0d want n=8 b4=80.. b7=200", got.size());
      end
   endtask

   task automatic test_len_56();
      msg_q.delete();
      for (int i = 0; i < 56; i++) msg_q.push_back(8'(i + 1));
      run_msg(0, 0, 0, 0);
      total++;
      if (got.size() != 8 || got[3][63:0] !== 64'h8000000000000000 || got[4] !== 128'd0
          || got[7] !== 128'h1c0) begin
         bad++;
         $display("FAIL len56_lit: got n=%0d want n=8 b3lo=80.. b4=0 b7=1c0", got.size());
      end
   endtask

   task automatic test_backpressure();
      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
      run_msg(0, 0, 0, 0);
      ref_run = got;
      run_msg(0, 0, 1, 0);
      total++;
      if (got != ref_run) begin
         bad++;
         $display("FAIL stall_sequence: got n=%0d want n=%0d identical", got.size(), ref_run.size());
      end
   endtask

   task automatic test_reset_mid();
      int sent = 0;
      for (int c = 0; c < 50 && sent < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         in_last  = 1'b0;
         in_bytes = 4'd8;
         out_ready = 1'b1;
         #1;
         if (in_ready) sent++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_block_first, out_block_last, out_msg_last} !== 5'b0
          || out_data !== 128'd0 || sent != 3) begin
         bad++;
         $display("FAIL midreset_outputs: got v=%b rdy=%b data=%h sent=%0d want 0 0 0 3",
                  out_valid, in_ready, out_data, sent);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 0, 0, 0);
      check_abc("midreset_abc");
   endtask

   task automatic test_random();
      for (int m = 0; m < 40; m++) begin
         msg_q.delete();
         for (int i = 0, n = $urandom_range(0, 150); i < n; i++) msg_q.push_back(8'($urandom));
         run_msg(1, 1, 0, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_abc();
      test_block_64();
      test_len_56();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jh512_msg_padder.md
Name: jh512_msg_padder

Overview:
- Upstream feeder for the JH512 compression core.
- Accepts a byte-aligned message as a stream of 64-bit words with valid/ready.
- Applies JH-512 padding: 0x80 marker, zero fill, 128-bit big-endian bit length. The padded message is always a multiple of 512 bits and carries at least 512 bits of padding.
- Emits 128-bit beats, the core's data width, four beats per 512-bit block, with block/message framing flags.

Parameters:
- LEN_W, 64, width of the internal message bit-length counter. Bits 127:LEN_W of the length field are sent as zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  padder can accept a word this cycle.
- in_data  in  64  message bytes, big-endian; byte 0 is in_data[63:56].
- in_last  in  1  word is the final word of the message.
- in_bytes  in  4  valid bytes in a last word, 0..8. Ignored (treated as 8) when in_last=0. Valid bytes are the leading bytes.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  128  padded beat, big-endian; block byte 0 is out_data[127:120] of the first beat.
- out_block_first  out  1  beat is beat 0 of a 512-bit block.
- out_block_last  out  1  beat is beat 3 of a block.
- out_msg_last  out  1  beat is beat 3 of the final block of the message.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, in_ready=0. Byte-position counter pos[5:0]=0, length counter=0, state=S_MSG, beat buffer cleared.
- After rst_n deasserts: in_ready=1 on the first clock edge.
- Any partially assembled message is discarded on reset. The next message starts a fresh block with its length counted from 0.
- Handshakes:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - out_data and all flags hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Beat assembly:
  - A two-word staging register fills the high half, then the low half.
  - Once both halves are complete, the beat moves into a one-entry output buffer.
  - in_ready=0 while the output buffer is full and staging is complete, or while state is not S_MSG.
- Latency: a beat appears on out_valid the cycle after the transfer of the word that completes it.
- pos counts the byte offset within the current 64-byte block and wraps mod 64. Length counter += 8*bytes for each accepted word.
- States:
  - S_MSG: accept words. On a last word with in_bytes=b:
    - write b data bytes; the remaining bytes of that word are 0x00;
    - if b<8, byte b of the word is 0x80 and the marker is marked done; if b=8, the marker is still pending;
    - go to S_FILL.
  - S_FILL: complete the current block with zero beats.
    - If the marker is pending and pos!=0, the first fill byte is 0x80 and the marker is marked done.
    - If pos==0 on entry, S_FILL emits nothing and the marker stays pending.
    - When the block boundary is reached, go to S_FINAL.
  - S_FINAL: emit exactly 4 beats.
    - Byte 0 = 0x80 if the marker is still pending, else 0x00.
    - Bytes 1..47 = 0x00.
    - Bytes 48..63 = 128-bit bit length, big-endian.
    - out_msg_last=1 on beat 3. After that transfer, clear the counters and return to S_MSG.
- Resulting padded size: for message length L bytes, padding is 64 + ((64 - L mod 64) mod 64) bytes. The final block is always padding-only.
- Empty message: in_last with in_bytes=0 and pos=0 produces only the 4-beat final block.
- Block flags: out_block_first is asserted on every beat where the beat index within its block is 0; out_block_last on index 3. This holds in all states.
- A word with in_last=1 and in_bytes>8 is treated as in_bytes=8.
- Messages longer than 2^(LEN_W-3) bytes are unsupported; the length counter wraps.

Test Plan:
1. Empty message (one word, in_last=1, in_bytes=0) -> 4 beats:
   - beat0 = 0x80 followed by 120 zero bits, block_first=1;
   - beats 1-2 = 0;
   - beat3 = 0, block_last=1, msg_last=1.
2. "abc" (in_data=0x616263xx..., in_bytes=3) -> 8 beats:
   - beat0 = 0x61626380 followed by zeros; beats 1-3 zero;
   - beats 4-6 zero; beat7 = 0x...0018 with msg_last=1.
3. 64-byte message (8 full words) -> 4 data beats, then final block beat0 = 0x80 followed by zeros, beat3 low 128 bits = 0x200. Total 8 beats, msg_last on beat 7.
4. 56-byte message (7 words, last in_bytes=8) -> beat3 = bytes 48..55, then 0x80, then 7 zero bytes; final block beat0 = 0; beat3 = 0x1C0.
5. Backpressure: out_ready=0 for 10 cycles mid-message -> in_ready drops within 1 cycle; out_data and flags stay constant; full beat sequence is identical to the no-stall run.
6. Reset mid-message: rst_n=0 after 3 words, then a new 3-byte message -> all outputs 0 during reset; output matches scenario 2 exactly, with length 0x18.
